// File: rtl/cfg_word_sequencer.sv
// cfg_word_sequencer: read-side sequencer for the configuration word store.
// Accepts one job descriptor (start address, stride, start/end latency window),
// issues strided store reads inside that window and presents each returned
// word split into configOut/controlOut with a cfgValid strobe.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   valid                 descriptor strobe (ignored while busy)
//   startAddr             first read address
//   strideInterval        address increment per word (0 rereads the same word)
//   startLatency          cycle offset of the first read
//   endLatency            cycle offset one past the last read
//   mem_rd_en, mem_addr   store read request
//   mem_rd_data           store read data, sampled at the edge after mem_rd_en
//   configOut/controlOut  upper/lower fields of the last returned word
//   cfgValid              configOut/controlOut qualify this cycle
//   busy                  job in progress
//   done                  one-cycle pulse at job end (also on error)
//   err                   one-cycle pulse for an empty or inverted window
module cfg_word_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CFG_W  = 7,
  parameter int unsigned CTL_W  = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [ADDR_W-1:0]      startAddr,
  input  logic [3:0]             strideInterval,
  input  logic [15:0]            startLatency,
  input  logic [15:0]            endLatency,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [CFG_W+CTL_W-1:0] mem_rd_data,
  output logic [CFG_W-1:0]       configOut,
  output logic [CTL_W-1:0]       controlOut,
  output logic                   cfgValid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned STRIDE_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} stateT;

  stateT               state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [ADDR_W-1:0]   ptr, ptrNext;
  logic [CNT_W-1:0]    startLatReg, startLatNext;
  logic [CNT_W-1:0]    endLatReg, endLatNext;
  logic [STRIDE_W-1:0] strideReg, strideNext;
  logic                rdEnNext;
  logic [ADDR_W-1:0]   addrNext;
  logic                busyNext, doneNext, errNext;

  // State, job context and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      startLatReg <= '0;
      endLatReg   <= '0;
      strideReg   <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      ptr         <= ptrNext;
      startLatReg <= startLatNext;
      endLatReg   <= endLatNext;
      strideReg   <= strideNext;
      mem_rd_en   <= rdEnNext;
      mem_addr    <= addrNext;
      busy        <= busyNext;
      done        <= doneNext;
      err         <= errNext;
    end
  end

  // Capture the store word on the edge following each read request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      configOut  <= '0;
      controlOut <= '0;
      cfgValid   <= 1'b0;
    end else begin
      cfgValid <= mem_rd_en;
      if (mem_rd_en) begin
        configOut  <= mem_rd_data[CFG_W+CTL_W-1:CTL_W];
        controlOut <= mem_rd_data[CTL_W-1:0];
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    ptrNext      = ptr;
    startLatNext = startLatReg;
    endLatNext   = endLatReg;
    strideNext   = strideReg;
    rdEnNext     = 1'b0;
    addrNext     = mem_addr;
    doneNext     = 1'b0;
    errNext      = 1'b0;

    case (state)
      IDLE: begin
        if (valid) begin
          cntNext      = '0;
          startLatNext = startLatency;
          endLatNext   = endLatency;
          strideNext   = strideInterval;
          ptrNext      = startAddr;
          if (endLatency <= startLatency) begin
            errNext  = 1'b1;
            doneNext = 1'b1;
          end else if (startLatency == CNT_W'(0)) begin
            stateNext = READ;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        // READ is entered in the cycle where the count reaches startLatency
        cntNext = cnt + CNT_W'(1);
        if (cntNext == startLatReg) begin
          stateNext = READ;
        end
      end
      READ: begin
        rdEnNext = 1'b1;
        addrNext = ptr;
        ptrNext  = ptr + ADDR_W'(strideReg);
        cntNext  = cnt + CNT_W'(1);
        if (cnt == endLatReg - CNT_W'(1)) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the final read has been captured (no request left in flight)
        if (!mem_rd_en && cfgValid) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_cfg_word_sequencer.sv
// Testbench for cfg_word_sequencer: table of job descriptors plus hand-written
// sequences (mid-job valid, back-to-back jobs, mid-job reset). Expected read
// addresses and returned words are queued when a job is issued and popped as
// the DUT produces reads and cfgValid words.
module tb_cfg_word_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CFG_W  = 7;
  localparam int unsigned CTL_W  = 36;
  localparam int unsigned WORD_W = CFG_W + CTL_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [ADDR_W-1:0] startAddr;
  logic [3:0]        strideInterval;
  logic [15:0]       startLatency;
  logic [15:0]       endLatency;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rd_data;
  logic [CFG_W-1:0]  configOut;
  logic [CTL_W-1:0]  controlOut;
  logic              cfgValid;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  cfg_word_sequencer #(.ADDR_W(ADDR_W), .CFG_W(CFG_W), .CTL_W(CTL_W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .startAddr(startAddr),
    .strideInterval(strideInterval), .startLatency(startLatency),
    .endLatency(endLatency), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .configOut(configOut), .controlOut(controlOut),
    .cfgValid(cfgValid), .busy(busy), .done(done), .err(err)
  );

  // Store contents: control field low bits = address, config field = address ^ 0x55
  function automatic logic [WORD_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    logic [CFG_W-1:0] c;
    logic [CTL_W-1:0] k;
    c = CFG_W'(a) ^ 7'h55;
    k = 36'h9_0000_0000 | CTL_W'(a);
    return {c, k};
  endfunction

  assign mem_rd_data = mem_rd_en ? memWord(mem_addr) : '0;

  typedef struct {
    logic [ADDR_W-1:0] sa;
    logic [3:0]        st;
    logic [15:0]       sl;
    logic [15:0]       el;
    logic              expErr;
    int                expReads;
  } vecT;

  vecT vecs[8];

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;
  int nRd, firstRd, lastRd, doneCyc, errCyc, doneCnt;
  logic busySeen;
  logic [ADDR_W-1:0] addrQ[$];
  logic [WORD_W-1:0] dataQ[$];
  logic [WORD_W-1:0] lastWord;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearMon();
    nRd = 0; firstRd = -1; lastRd = -1; doneCyc = -1; errCyc = -1; doneCnt = 0;
    busySeen = 1'b0;
  endtask

  // Sample outputs mid-cycle and score reads/words against the queues
  task automatic sample();
    if (mem_rd_en) begin
      nRd++;
      if (firstRd < 0) firstRd = cyc;
      lastRd = cyc;
      if (addrQ.size() == 0) chk("read_expected", 64'(addrQ.size()), 64'd1);
      else chk("mem_addr", 64'(mem_addr), 64'(addrQ.pop_front()));
    end
    if (cfgValid) begin
      if (dataQ.size() == 0) chk("word_expected", 64'(dataQ.size()), 64'd1);
      else chk("cfg_word", 64'({configOut, controlOut}), 64'(dataQ.pop_front()));
    end
    if (done) begin doneCnt++; doneCyc = cyc; end
    if (err) errCyc = cyc;
    if (busy) busySeen = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic startJob(input vecT v, output int ts);
    int a;
    startAddr      = v.sa;
    strideInterval = v.st;
    startLatency   = v.sl;
    endLatency     = v.el;
    valid          = 1'b1;
    ts             = cyc;
    if (!v.expErr) begin
      for (int k = 0; k < int'(v.el) - int'(v.sl); k++) begin
        a = (int'(v.sa) + k * int'(v.st)) % 32;
        addrQ.push_back(ADDR_W'(a));
        dataQ.push_back(memWord(ADDR_W'(a)));
        lastWord = memWord(ADDR_W'(a));
      end
    end
    tick();
    valid = 1'b0;
    clearMon();
  endtask

  task automatic finishJob(input vecT v, input int ts, input string tag);
    int bound;
    bound = v.expErr ? ts + 4 : ts + int'(v.el) + 6;
    while (cyc < bound) tick();
    if (v.expErr) begin
      chk({tag, "_err_cyc"}, 64'(errCyc), 64'(ts + 1));
      chk({tag, "_done_cyc"}, 64'(doneCyc), 64'(ts + 1));
      chk({tag, "_done_cnt"}, 64'(doneCnt), 64'd1);
      chk({tag, "_reads"}, 64'(nRd), 64'd0);
      chk({tag, "_busy"}, 64'(busySeen), 64'd0);
    end else begin
      chk({tag, "_first_rd"}, 64'(firstRd), 64'(ts + 2 + int'(v.sl)));
      chk({tag, "_last_rd"}, 64'(lastRd), 64'(ts + 1 + int'(v.el)));
      chk({tag, "_reads"}, 64'(nRd), 64'(v.expReads));
      chk({tag, "_done_cyc"}, 64'(doneCyc), 64'(ts + 3 + int'(v.el)));
      chk({tag, "_done_cnt"}, 64'(doneCnt), 64'd1);
      chk({tag, "_no_err"}, 64'(errCyc), 64'(-1));
      chk({tag, "_addrq_left"}, 64'(addrQ.size()), 64'd0);
      chk({tag, "_dataq_left"}, 64'(dataQ.size()), 64'd0);
      chk({tag, "_hold"}, 64'({configOut, controlOut}), 64'(lastWord));
    end
  endtask

  function automatic logic [63:0] allOuts();
    return 64'({mem_rd_en, mem_addr, configOut, controlOut, cfgValid, busy, done, err});
  endfunction

  initial begin
    int ts, tb2, nBefore;
    vecT vm, vr;

    vecs[0] = '{sa: 5'd0,  st: 4'd1,  sl: 16'd0,  el: 16'd9,  expErr: 1'b0, expReads: 9};
    vecs[1] = '{sa: 5'd0,  st: 4'd1,  sl: 16'd9,  el: 16'd12, expErr: 1'b0, expReads: 3};
    vecs[2] = '{sa: 5'd5,  st: 4'd1,  sl: 16'd15, el: 16'd20, expErr: 1'b0, expReads: 5};
    vecs[3] = '{sa: 5'd30, st: 4'd3,  sl: 16'd0,  el: 16'd4,  expErr: 1'b0, expReads: 4};
    vecs[4] = '{sa: 5'd0,  st: 4'd1,  sl: 16'd6,  el: 16'd6,  expErr: 1'b1, expReads: 0};
    vecs[5] = '{sa: 5'd0,  st: 4'd1,  sl: 16'd8,  el: 16'd3,  expErr: 1'b1, expReads: 0};
    vecs[6] = '{sa: 5'd31, st: 4'd0,  sl: 16'd2,  el: 16'd5,  expErr: 1'b0, expReads: 3};
    vecs[7] = '{sa: 5'd17, st: 4'd15, sl: 16'd1,  el: 16'd2,  expErr: 1'b0, expReads: 1};

    rst = 1'b0; valid = 1'b0; startAddr = '0; strideInterval = '0;
    startLatency = '0; endLatency = '0;
    clearMon();
    tick(); tick();
    chk("reset_outputs", allOuts(), 64'd0);
    rst = 1'b1;
    tick();

    // Table-driven jobs
    for (int i = 0; i < 8; i++) begin
      if (i == 2) continue;
      startJob(vecs[i], ts);
      finishJob(vecs[i], ts, $sformatf("vec%0d", i));
    end

    // A second valid mid-job (with an inverted window) must be ignored
    startJob(vecs[2], ts);
    for (int k = 0; k < 5; k++) tick();
    startAddr = 5'd3; strideInterval = 4'd7; startLatency = 16'd5; endLatency = 16'd1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    finishJob(vecs[2], ts, "midvalid");

    // Back-to-back: next valid accepted in the cycle done is high
    startJob(vecs[0], ts);
    while (cyc < ts + 3 + int'(vecs[0].el)) tick();
    #3;
    chk("b2b_done_a", 64'(done), 64'd1);
    chk("b2b_busy_a", 64'(busy), 64'd0);
    startJob(vecs[3], tb2);
    finishJob(vecs[3], tb2, "b2b_b");

    // Reset after 5 reads aborts the job; a new job then runs normally
    vr = '{sa: 5'd10, st: 4'd1, sl: 16'd0, el: 16'd20, expErr: 1'b0, expReads: 20};
    startJob(vr, ts);
    for (int k = 0; k < 30 && nRd < 5; k++) tick();
    chk("rst_reads_before", 64'(nRd), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", allOuts(), 64'd0);
    addrQ.delete();
    dataQ.delete();
    nBefore = nRd;
    for (int k = 0; k < 4; k++) tick();
    chk("rst_no_done", 64'(doneCnt), 64'd0);
    chk("rst_no_reads", 64'(nRd), 64'(nBefore));
    rst = 1'b1;
    tick();
    vm = '{sa: 5'd20, st: 4'd2, sl: 16'd3, el: 16'd7, expErr: 1'b0, expReads: 4};
    startJob(vm, ts);
    finishJob(vm, ts, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
